whack_game_ctrl: RTL and testbench



---
 rtl/whack_game_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_whack_game_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : whack_game_ctrl
// Purpose  : Whack-a-mole round sequencer: position request, mole window,
//            hit/miss judging, score/miss keeping and window speed-up.
// Revision : 1.0 - initial release
// ============================================================================
module whack_game_ctrl #(
  parameter int MOLE_TICKS   = 100000000,
  parameter int MIN_TICKS    = 25000000,
  parameter int STEP_TICKS   = 12500000,
  parameter int GAP_TICKS    = 50000000,
  parameter int SPEEDUP_HITS = 4,
  parameter int MAX_MISSES   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [4:0] i_btn,
  input  logic [2:0] i_mole_position,
  output logic       o_change_position,
  output logic [2:0] o_mole_pos,
  output logic       o_mole_visible,
  output logic [7:0] o_score,
  output logic [1:0] o_misses,
  output logic       o_hit,
  output logic       o_miss,
  output logic       o_game_over,
  output logic [2:0] o_state
);

  localparam logic [27:0] MOLE_W     = 28'(MOLE_TICKS);
  localparam logic [27:0] MIN_W      = 28'(MIN_TICKS);
  localparam logic [27:0] STEP_W     = 28'(STEP_TICKS);
  localparam logic [27:0] SHRINK_MIN = 28'(MIN_TICKS + STEP_TICKS);
  localparam logic [27:0] GAP_LAST   = 28'(GAP_TICKS - 1);
  localparam logic [7:0]  SPD_MASK   = 8'(SPEEDUP_HITS - 1);
  localparam logic [1:0]  MAX_M      = 2'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LATCH = 3'd2,
    S_UP    = 3'd3,
    S_GAP   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t      state_q,   state_d;
  logic [27:0] timer_q,   timer_d;
  logic [27:0] window_q,  window_d;
  logic [7:0]  score_q,   score_d;
  logic [1:0]  misses_q,  misses_d;
  logic [2:0]  mole_pos_q, mole_pos_d;
  logic        change_q,  change_d;
  logic        visible_q, visible_d;
  logic        hit_q,     hit_d;
  logic        miss_q,    miss_d;
  logic        over_q,    over_d;

  logic [4:0]  btn_mask;
  logic        btn_hit;
  logic        btn_wrong;
  logic [7:0]  score_inc;
  logic [1:0]  misses_inc;
  logic        speedup;

  always_comb begin
    btn_mask   = 5'd1 << mole_pos_q;
    btn_hit    = |(i_btn & btn_mask);
    btn_wrong  = |(i_btn & ~btn_mask);
    score_inc  = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
    misses_inc = misses_q + 2'd1;
    speedup    = ((score_inc & SPD_MASK) == 8'd0) && (score_inc != 8'd0);

    state_d    = state_q;
    timer_d    = timer_q;
    window_d   = window_q;
    score_d    = score_q;
    misses_d   = misses_q;
    mole_pos_d = mole_pos_q;
    visible_d  = visible_q;
    over_d     = over_q;
    change_d   = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          score_d  = 8'd0;
          misses_d = 2'd0;
          timer_d  = 28'd0;
          window_d = MOLE_W;
          over_d   = 1'b0;
          change_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        mole_pos_d = i_mole_position;
        if (i_mole_position > 3'd4) begin
          change_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          timer_d   = 28'd0;
          visible_d = 1'b1;
          state_d   = S_UP;
        end
      end
      S_UP: begin
        // Correct hole wins over stray bits pressed in the same cycle.
        if (btn_hit) begin
          score_d   = score_inc;
          hit_d     = 1'b1;
          visible_d = 1'b0;
          timer_d   = 28'd0;
          state_d   = S_GAP;
          if (speedup) begin
            window_d = (window_q >= SHRINK_MIN) ? window_q - STEP_W : MIN_W;
          end
        end else if (btn_wrong || (timer_q == window_q - 28'd1)) begin
          misses_d  = misses_inc;
          miss_d    = 1'b1;
          visible_d = 1'b0;
          timer_d   = 28'd0;
          if (misses_inc == MAX_M) begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          timer_d = timer_q + 28'd1;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d  = 28'd0;
          change_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          timer_d = timer_q + 28'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 28'd0;
      window_q   <= MOLE_W;
      score_q    <= 8'd0;
      misses_q   <= 2'd0;
      mole_pos_q <= 3'd0;
      change_q   <= 1'b0;
      visible_q  <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      window_q   <= window_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      mole_pos_q <= mole_pos_d;
      change_q   <= change_d;
      visible_q  <= visible_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      over_q     <= over_d;
    end
  end

  assign o_change_position = change_q;
  assign o_mole_pos        = mole_pos_q;
  assign o_mole_visible    = visible_q;
  assign o_score           = score_q;
  assign o_misses          = misses_q;
  assign o_hit             = hit_q;
  assign o_miss            = miss_q;
  assign o_game_over       = over_q;
  assign o_state           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_whack_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_whack_game_ctrl
// Purpose  : Directed self-checking bench for whack_game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_whack_game_ctrl;

  localparam int MOLE_TICKS   = 8;
  localparam int MIN_TICKS    = 4;
  localparam int STEP_TICKS   = 2;
  localparam int GAP_TICKS    = 4;
  localparam int SPEEDUP_HITS = 2;
  localparam int MAX_MISSES   = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_UP    = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [4:0] i_btn;
  logic [2:0] i_mole_position;
  logic       o_change_position;
  logic [2:0] o_mole_pos;
  logic       o_mole_visible;
  logic [7:0] o_score;
  logic [1:0] o_misses;
  logic       o_hit;
  logic       o_miss;
  logic       o_game_over;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  whack_game_ctrl #(
    .MOLE_TICKS  (MOLE_TICKS),
    .MIN_TICKS   (MIN_TICKS),
    .STEP_TICKS  (STEP_TICKS),
    .GAP_TICKS   (GAP_TICKS),
    .SPEEDUP_HITS(SPEEDUP_HITS),
    .MAX_MISSES  (MAX_MISSES)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_btn            (i_btn),
    .i_mole_position  (i_mole_position),
    .o_change_position(o_change_position),
    .o_mole_pos       (o_mole_pos),
    .o_mole_visible   (o_mole_visible),
    .o_score          (o_score),
    .o_misses         (o_misses),
    .o_hit            (o_hit),
    .o_miss           (o_miss),
    .o_game_over      (o_game_over),
    .o_state          (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [20:0] all_outs();
    return {o_change_position, o_mole_pos, o_mole_visible, o_score, o_misses,
            o_hit, o_miss, o_game_over, o_state};
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic start_game();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (o_state != st && n < budget) begin
      step();
      n++;
    end
    check(tag, o_state, st);
  endtask

  // From a REQ cycle: the generator value is sampled in LATCH, UP follows.
  task automatic enter_up(input logic [2:0] pos);
    i_mole_position = pos;
    step();
    step();
  endtask

  task automatic hit_round(input string tag, input logic [2:0] pos, input logic [7:0] exp_score);
    enter_up(pos);
    i_btn = 5'd1 << pos;
    step();
    i_btn = 5'd0;
    check({tag, "_hit"}, o_hit, 1);
    check({tag, "_score"}, o_score, exp_score);
    wait_state({tag, "_req"}, ST_REQ, 10);
  endtask

  task automatic timeout_round(input string tag, input logic [2:0] pos, input int exp_len,
                               input logic [1:0] exp_misses);
    int n = 0;
    enter_up(pos);
    while (o_mole_visible && n < 20) begin
      n++;
      step();
    end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_miss"}, o_miss, 1);
    check({tag, "_misses"}, o_misses, exp_misses);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_btn = 5'd0;
    i_mole_position = 3'd0;
    #2;
    check("reset_outs", all_outs(), 0);
    step();
    step();
    i_rst = 1'b0;
    step();
    check("idle_state", o_state, ST_IDLE);

    // Basic hit on the second visible cycle, then exact gap length.
    i_mole_position = 3'd3;
    start_game();
    check("a_req_chg", o_change_position, 1);
    check("a_req_state", o_state, ST_REQ);
    step();
    check("a_latch_state", o_state, ST_LATCH);
    check("a_latch_chg", o_change_position, 0);
    step();
    check("a_up_state", o_state, ST_UP);
    check("a_up_vis", o_mole_visible, 1);
    check("a_up_pos", o_mole_pos, 3);
    step();
    i_btn = 5'b01000;
    step();
    i_btn = 5'd0;
    check("a_hit", o_hit, 1);
    check("a_score", o_score, 1);
    check("a_vis_off", o_mole_visible, 0);
    check("a_gap_state", o_state, ST_GAP);
    for (int i = 0; i < 3; i++) begin
      step();
      check("a_gap_hold", o_state, ST_GAP);
      check("a_gap_chg", o_change_position, 0);
      check("a_gap_hitlow", o_hit, 0);
    end
    step();
    check("a_req2_state", o_state, ST_REQ);
    check("a_req2_chg", o_change_position, 1);

    // Out-of-range position forces a re-request; later input changes are ignored.
    i_mole_position = 3'd5;
    step();
    step();
    check("r_retry_state", o_state, ST_REQ);
    check("r_retry_chg", o_change_position, 1);
    check("r_retry_vis", o_mole_visible, 0);
    i_mole_position = 3'd2;
    step();
    step();
    check("r_up_state", o_state, ST_UP);
    check("r_up_pos", o_mole_pos, 2);
    i_mole_position = 3'd4;
    step();
    check("r_pos_hold", o_mole_pos, 2);

    // Timeouts to game over with score held, then restart from OVER.
    do_reset();
    start_game();
    hit_round("b1", 3'd0, 8'd1);
    timeout_round("b2", 3'd1, 8, 2'd1);
    check("b2_state", o_state, ST_GAP);
    i_btn = 5'b11111;
    step();
    i_btn = 5'd0;
    check("g_score", o_score, 1);
    check("g_misses", o_misses, 1);
    check("g_state", o_state, ST_GAP);
    check("g_pulses", {o_hit, o_miss}, 0);
    wait_state("b2_req", ST_REQ, 10);
    timeout_round("b3", 3'd2, 8, 2'd2);
    wait_state("b3_req", ST_REQ, 10);
    timeout_round("b4", 3'd3, 8, 2'd3);
    check("b4_over", o_game_over, 1);
    check("b4_state", o_state, ST_OVER);
    check("b4_score", o_score, 1);
    step();
    step();
    step();
    check("b_hold_state", o_state, ST_OVER);
    check("b_hold_score", o_score, 1);
    check("b_hold_misses", o_misses, 3);
    check("b_hold_chg", o_change_position, 0);
    start_game();
    check("b_restart_state", o_state, ST_REQ);
    check("b_restart_chg", o_change_position, 1);
    check("b_restart_score", o_score, 0);
    check("b_restart_misses", o_misses, 0);
    check("b_restart_over", o_game_over, 0);

    // Window shrink 8 -> 6 -> 4 and floor at 4.
    do_reset();
    start_game();
    hit_round("c1", 3'd0, 8'd1);
    hit_round("c2", 3'd1, 8'd2);
    timeout_round("c_w6", 3'd2, 6, 2'd1);
    wait_state("c_w6_req", ST_REQ, 10);
    hit_round("c3", 3'd3, 8'd3);
    hit_round("c4", 3'd4, 8'd4);
    timeout_round("c_w4", 3'd0, 4, 2'd2);
    wait_state("c_w4_req", ST_REQ, 10);
    hit_round("c5", 3'd1, 8'd5);
    hit_round("c6", 3'd2, 8'd6);
    hit_round("c7", 3'd3, 8'd7);
    hit_round("c8", 3'd4, 8'd8);
    timeout_round("c_floor", 3'd0, 4, 2'd3);
    check("c_over_state", o_state, ST_OVER);
    check("c_over_score", o_score, 8);

    // Multi-bit press including the mole is a hit; a wrong hole is a miss.
    do_reset();
    start_game();
    enter_up(3'd1);
    i_btn = 5'b00011;
    step();
    i_btn = 5'd0;
    check("d_multi_hit", o_hit, 1);
    check("d_multi_miss", o_miss, 0);
    check("d_multi_score", o_score, 1);
    wait_state("d_req", ST_REQ, 10);
    enter_up(3'd1);
    i_btn = 5'b00100;
    step();
    i_btn = 5'd0;
    check("d_wrong_miss", o_miss, 1);
    check("d_wrong_hit", o_hit, 0);
    check("d_wrong_misses", o_misses, 1);
    check("d_wrong_score", o_score, 1);
    check("d_wrong_state", o_state, ST_GAP);

    // Asynchronous reset in the middle of UP.
    wait_state("e_req", ST_REQ, 10);
    enter_up(3'd4);
    step();
    check("e_up_vis", o_mole_visible, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("e_async_outs", all_outs(), 0);
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("e_idle_state", o_state, ST_IDLE);
      check("e_idle_chg", o_change_position, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
